// File: rtl/digit_serial_pkg.sv
// Shared types and helpers for the digit-serial adder: FSM state encoding,
// digit width and the digit-counter width function.
package digit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIGIT_W = 2;

  // Counter width for n digits, never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/digit_serial_adder_slice.sv
// add2_slice: combinational 2-bit full adder, the one arithmetic slice that
// the digit-serial adder steps across its operands.
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  logic [2:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {2'b00, ci};
  assign s     = total[1:0];
  assign co    = total[2];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: one 2-bit slice per cycle, LSD first, with valid/ready
// on both sides. Define DIGIT_SERIAL_ADDER_SUB_EN to add the subtract port.
module digit_serial_adder
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = clog2(WIDTH / DIGIT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH / DIGIT_W - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0]         a_q, b_q, sum_q;
  logic                     carry_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [DIGIT_W-1:0]       slice_s;
  logic                     slice_co;
  logic [WIDTH+DIGIT_W-1:0] sum_shift;
  logic [WIDTH-1:0]         b_load;
  logic                     c_load;
  logic                     accept;

  add2_slice u_slice (
    .a  (a_q[DIGIT_W-1:0]),
    .b  (b_q[DIGIT_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1; cout then means "no borrow".
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && (state_q == IDLE);
  assign sum_shift = {slice_s, sum_q};
  assign sum       = sum_q;
  assign cout      = carry_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_load;
      carry_q <= c_load;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      // Each digit enters at the top; after WIDTH/2 steps digit 0 sits at the LSB.
      a_q     <= a_q >> DIGIT_W;
      b_q     <= b_q >> DIGIT_W;
      sum_q   <= sum_shift[WIDTH+DIGIT_W-1:DIGIT_W];
      carry_q <= slice_co;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: a WIDTH=8 instance for the main
// scenarios and a WIDTH=2 instance swept over all inputs.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cin8 = 1'b0, cout8, sub8 = 1'b0;

  logic       in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic       cin2 = 1'b0, cout2, sub2 = 1'b0;

  int checks = 0;
  int errors = 0;

  digit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
  );

  digit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub2),
`endif
    .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2), .cin(cin2),
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2)
  );

  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready8, out_valid8, sum8, cout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset8 got rdy=%b vld=%b sum=%h cout=%b want rdy=1 vld=0 sum=00 cout=0",
               in_ready8, out_valid8, sum8, cout8);
    end
    checks++;
    if ({in_ready2, out_valid2, sum2, cout2} !== {1'b1, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset2 got rdy=%b vld=%b sum=%h cout=%b want rdy=1 vld=0 sum=0 cout=0",
               in_ready2, out_valid2, sum2, cout2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain();
    int lat;
    start8(8'hFF, 8'h01, 1'b0);
    wait_valid8(lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL latency_ff01 got %0d want 4", lat);
    end
    checks++;
    if ({cout8, sum8} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL sum_ff01 got cout=%b sum=%h want cout=1 sum=00", cout8, sum8);
    end
    release8();
    checks++;
    if ({out_valid8, in_ready8} !== 2'b01) begin
      errors++;
      $display("FAIL return_idle got vld=%b rdy=%b want vld=0 rdy=1", out_valid8, in_ready8);
    end
  endtask

  task automatic test_ready_span();
    int lat = 0;
    int bad_rdy = 0;
    start8(8'h5A, 8'h33, 1'b1);
    if (in_ready8 !== 1'b0) bad_rdy++;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready8 !== 1'b0) bad_rdy++;
    end
    checks++;
    if (bad_rdy !== 0 || lat !== 4) begin
      errors++;
      $display("FAIL ready_span got bad_rdy=%0d lat=%0d want bad_rdy=0 lat=4", bad_rdy, lat);
    end
    checks++;
    if ({cout8, sum8} !== {1'b0, 8'h8E}) begin
      errors++;
      $display("FAIL sum_5a33 got cout=%b sum=%h want cout=0 sum=8e", cout8, sum8);
    end
    release8();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    start8(8'hC3, 8'h4E, 1'b1);
    wait_valid8(lat);
    for (int i = 0; i < 3; i++) begin
      a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
      in_valid8 = (i != 1);
      @(posedge clk); #1;
      if ({out_valid8, in_ready8, cout8, sum8} !== {1'b1, 1'b0, 1'b1, 8'h12}) bad++;
    end
    in_valid8 = 1'b0;
    checks++;
    if (bad !== 0 || lat !== 4) begin
      errors++;
      $display("FAIL backpressure got bad=%0d lat=%0d vld=%b sum=%h cout=%b want bad=0 lat=4 sum=12 cout=1",
               bad, lat, out_valid8, sum8, cout8);
    end
    release8();
    checks++;
    if ({out_valid8, in_ready8} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid8, in_ready8);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start8(8'hFF, 8'hFF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready8, out_valid8, sum8, cout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_run got rdy=%b vld=%b sum=%h cout=%b want rdy=1 vld=0 sum=00 cout=0",
               in_ready8, out_valid8, sum8, cout8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start8(8'h01, 8'h01, 1'b0);
    wait_valid8(lat);
    checks++;
    if ({lat, cout8, sum8} !== {32'd4, 1'b0, 8'h02}) begin
      errors++;
      $display("FAIL after_reset got lat=%0d cout=%b sum=%h want lat=4 cout=0 sum=02", lat, cout8, sum8);
    end
    release8();
  endtask

  task automatic test_width2();
    int lat;
    int bad = 0;
    logic [2:0] want;
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a2 = ai[1:0]; b2 = bi[1:0]; cin2 = ci[0]; in_valid2 = 1'b1;
          @(posedge clk); #1;
          in_valid2 = 1'b0;
          lat = 0;
          while (!out_valid2 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
          end
          want = 3'(ai + bi + ci);
          checks++;
          if (lat !== 1 || {cout2, sum2} !== want) begin
            errors++;
            bad++;
            $display("FAIL w2 a=%0d b=%0d cin=%0d got lat=%0d {cout,sum}=%0d want lat=1 %0d",
                     ai, bi, ci, lat, {cout2, sum2}, want);
          end
          out_ready2 = 1'b1;
          @(posedge clk); #1;
          out_ready2 = 1'b0;
        end
      end
    end
  endtask

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    sub8 = 1'b1;
    start8(8'h10, 8'h20, 1'b0);
    wait_valid8(lat);
    checks++;
    if ({lat, cout8, sum8} !== {32'd4, 1'b0, 8'hF0}) begin
      errors++;
      $display("FAIL sub_10_20 got lat=%0d cout=%b sum=%h want lat=4 cout=0 sum=f0", lat, cout8, sum8);
    end
    release8();
    start8(8'h20, 8'h10, 1'b0);
    wait_valid8(lat);
    checks++;
    if ({lat, cout8, sum8} !== {32'd4, 1'b1, 8'h10}) begin
      errors++;
      $display("FAIL sub_20_10 got lat=%0d cout=%b sum=%h want lat=4 cout=1 sum=10", lat, cout8, sum8);
    end
    release8();
    sub8 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_ready_span();
    test_backpressure();
    test_reset_mid_run();
    test_width2();
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
